// File: rtl/truth_table_engine.sv
// Programmable N-input boolean function unit: serially loaded truth table,
// registered live evaluation, and an exhaustive sweep that counts minterms.
module truth_table_engine #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         load_bit,
  output logic         load_done,
  output logic         table_ready,
  input  logic [N-1:0] x,
  output logic         z,
  input  logic         sweep_start,
  output logic         busy,
  output logic         sweep_valid,
  output logic [N-1:0] sweep_x,
  output logic         sweep_z,
  output logic         sweep_done,
  output logic [N:0]   ones_count
);
  localparam int DEPTH = 2**N;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] tbl;
  logic [N-1:0]     ptr;
  logic [N:0]       cnt;
  logic [N-1:0]     nxt_idx;
  logic             load_acc, sweep_acc, last_entry;

  always_comb begin
    state_nxt  = state;
    load_acc   = 1'b0;
    sweep_acc  = 1'b0;
    last_entry = (cnt == (N+1)'(DEPTH-1));
    nxt_idx    = cnt[N-1:0] + 1'b1;
    case (state)
      IDLE: begin
        load_acc = load_en;
        // load takes precedence over a same-cycle sweep request
        if (sweep_start && table_ready && !load_en) begin
          sweep_acc = 1'b1;
          state_nxt = SWEEP;
        end
      end
      SWEEP:   if (last_entry) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tbl         <= '0;
      ptr         <= '0;
      cnt         <= '0;
      z           <= 1'b0;
      load_done   <= 1'b0;
      table_ready <= 1'b0;
      busy        <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_x     <= '0;
      sweep_z     <= 1'b0;
      sweep_done  <= 1'b0;
      ones_count  <= '0;
    end else begin
      state      <= state_nxt;
      z          <= tbl[x];
      load_done  <= 1'b0;
      sweep_done <= 1'b0;
      if (load_acc) begin
        tbl[ptr] <= load_bit;
        ptr      <= ptr + 1'b1;
        if (ptr == N'(DEPTH-1)) begin
          load_done   <= 1'b1;
          table_ready <= 1'b1;
        end
      end
      // sweep outputs present entry cnt; it is tallied as the cycle closes
      case (state)
        IDLE: if (sweep_acc) begin
          cnt         <= '0;
          ones_count  <= '0;
          busy        <= 1'b1;
          sweep_valid <= 1'b1;
          sweep_x     <= '0;
          sweep_z     <= tbl[0];
        end
        SWEEP: begin
          ones_count <= ones_count + (N+1)'(tbl[cnt[N-1:0]]);
          cnt        <= cnt + 1'b1;
          if (last_entry) begin
            sweep_valid <= 1'b0;
            sweep_done  <= 1'b1;
          end else begin
            sweep_x <= nxt_idx;
            sweep_z <= tbl[nxt_idx];
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
